// File: rtl/csr_regfile_if.sv
// csr_regfile_if: CSR instruction, trap write and CSR export signals of the machine-mode CSR file.
// master: EXU/trap side (drives i_*, receives o_*); slave: csr_regfile.
// i_csr_addr/op/wen/src: CSR instruction; i_lsu_valid: commit strobe.
// i_mepc/mcause/mstatus_wen/wdata: trap-unit write ports.
// o_csr_rdata/o_csr_illegal: read result; o_mtvec/o_mepc/o_mstatus: exported state.
interface csr_regfile_if #(parameter int CPU_WIDTH = 32);
  logic [11:0]          i_csr_addr;
  logic [1:0]           i_csr_op;
  logic                 i_csr_wen;
  logic [CPU_WIDTH-1:0] i_csr_src;
  logic                 i_lsu_valid;
  logic                 i_mepc_wen;
  logic [CPU_WIDTH-1:0] i_mepc_wdata;
  logic                 i_mcause_wen;
  logic [CPU_WIDTH-1:0] i_mcause_wdata;
  logic                 i_mstatus_wen;
  logic [CPU_WIDTH-1:0] i_mstatus_wdata;
  logic [CPU_WIDTH-1:0] o_csr_rdata;
  logic                 o_csr_illegal;
  logic [CPU_WIDTH-1:0] o_mtvec;
  logic [CPU_WIDTH-1:0] o_mepc;
  logic [CPU_WIDTH-1:0] o_mstatus;
  modport master (
    output i_csr_addr, i_csr_op, i_csr_wen, i_csr_src, i_lsu_valid,
           i_mepc_wen, i_mepc_wdata, i_mcause_wen, i_mcause_wdata, i_mstatus_wen, i_mstatus_wdata,
    input  o_csr_rdata, o_csr_illegal, o_mtvec, o_mepc, o_mstatus
  );
  modport slave (
    input  i_csr_addr, i_csr_op, i_csr_wen, i_csr_src, i_lsu_valid,
           i_mepc_wen, i_mepc_wdata, i_mcause_wen, i_mcause_wdata, i_mstatus_wen, i_mstatus_wdata,
    output o_csr_rdata, o_csr_illegal, o_mtvec, o_mepc, o_mstatus
  );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR file (mstatus, mtvec, mepc, mcause, mcycle/h, mvendorid, marchid).
// i_clk/i_rst: clock and synchronous active-high reset; bus: csr_regfile_if slave port.
module csr_regfile #(
  parameter int                   CPU_WIDTH   = 32,
  parameter logic [CPU_WIDTH-1:0] MARCHID     = 32'h0000_5F5F,
  parameter logic [CPU_WIDTH-1:0] MSTATUS_RST = 32'h0000_1800
) (
  input logic          i_clk,
  input logic          i_rst,
  csr_regfile_if.slave bus
);
  localparam logic [CPU_WIDTH-1:0] MVENDORID = 32'h7973_7978;
  logic [CPU_WIDTH-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause;
  logic [63:0]          r_mcycle;
  logic [CPU_WIDTH-1:0] w_old, w_new, w_mepc;
  logic                 w_rw, w_ro, w_wr;
  always_comb begin
    w_old = '0;
    w_rw  = 1'b1;
    w_ro  = 1'b0;
    case (bus.i_csr_addr)
      12'h300: w_old = r_mstatus;
      12'h305: w_old = r_mtvec;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'hB00: w_old = r_mcycle[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hF11: begin w_old = MVENDORID; w_rw = 1'b0; w_ro = 1'b1; end
      12'hF12: begin w_old = MARCHID;   w_rw = 1'b0; w_ro = 1'b1; end
      default: w_rw = 1'b0;
    endcase
  end
  assign w_new = bus.i_csr_op == 2'b01 ? bus.i_csr_src :
                 bus.i_csr_op == 2'b10 ? w_old | bus.i_csr_src : w_old & ~bus.i_csr_src;
  assign w_wr  = bus.i_csr_op != 2'b00 && bus.i_csr_wen && bus.i_lsu_valid && w_rw;
  // trap port has priority over a software write to the same CSR
  assign w_mepc = bus.i_mepc_wen ? bus.i_mepc_wdata : w_wr && bus.i_csr_addr == 12'h341 ? w_new : r_mepc;
  assign bus.o_csr_rdata   = w_old;
  assign bus.o_csr_illegal = bus.i_csr_op != 2'b00 && (!(w_rw || w_ro) || (w_ro && bus.i_csr_wen));
  assign bus.o_mtvec       = r_mtvec;
  assign bus.o_mepc        = r_mepc;
  assign bus.o_mstatus     = r_mstatus;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
      r_mcycle  <= '0;
    end else begin
      r_mstatus <= bus.i_mstatus_wen ? bus.i_mstatus_wdata : w_wr && bus.i_csr_addr == 12'h300 ? w_new : r_mstatus;
      r_mcause  <= bus.i_mcause_wen ? bus.i_mcause_wdata : w_wr && bus.i_csr_addr == 12'h342 ? w_new : r_mcause;
      r_mtvec   <= w_wr && bus.i_csr_addr == 12'h305 ? {w_new[CPU_WIDTH-1:2], 2'b00} : r_mtvec;
      r_mepc    <= {w_mepc[CPU_WIDTH-1:2], 2'b00};
      // a software write to either half suppresses that cycle's increment
      r_mcycle  <= w_wr && bus.i_csr_addr == 12'hB00 ? {r_mcycle[63:32], w_new} :
                   w_wr && bus.i_csr_addr == 12'hB80 ? {w_new, r_mcycle[31:0]} : r_mcycle + 64'd1;
    end
  end
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed self-checking bench for csr_regfile.
module tb_csr_regfile;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  csr_regfile_if #(.CPU_WIDTH(32)) bus ();
  csr_regfile #(.CPU_WIDTH(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [1:0] op, input logic [11:0] addr, input logic wen,
                     input logic [31:0] src, input logic lv);
    bus.i_csr_op    = op;
    bus.i_csr_addr  = addr;
    bus.i_csr_wen   = wen;
    bus.i_csr_src   = src;
    bus.i_lsu_valid = lv;
    #1;
  endtask
  task automatic idle;
    bus.i_mepc_wen    = 1'b0;
    bus.i_mcause_wen  = 1'b0;
    bus.i_mstatus_wen = 1'b0;
    bus.i_mepc_wdata  = '0;
    bus.i_mcause_wdata = '0;
    bus.i_mstatus_wdata = '0;
    drv(2'b00, 12'h000, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_reset;
    idle();
    drv(2'b01, 12'h305, 1'b1, 32'hDEAD_BEE0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(2'b10, 12'hB00, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_mstatus !== 32'h0000_1800) begin n_fail++; $display("FAIL rst_mstatus got %h exp %h", bus.o_mstatus, 32'h1800); end
    n_chk++; if (bus.o_mtvec !== 32'h0) begin n_fail++; $display("FAIL rst_mtvec got %h exp 0", bus.o_mtvec); end
    n_chk++; if (bus.o_mepc !== 32'h0) begin n_fail++; $display("FAIL rst_mepc got %h exp 0", bus.o_mepc); end
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mcycle0 got %h exp 0", bus.o_csr_rdata); end
    tick();
    n_chk++; if (bus.o_csr_rdata !== 32'h1) begin n_fail++; $display("FAIL rst_mcycle1 got %h exp 1", bus.o_csr_rdata); end
    drv(2'b10, 12'hB80, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mcycleh got %h exp 0", bus.o_csr_rdata); end
    idle();
  endtask
  task automatic test_mtvec;
    drv(2'b01, 12'h305, 1'b1, 32'h8000_0103, 1'b1);
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mtvec_old got %h exp 0", bus.o_csr_rdata); end
    n_chk++; if (bus.o_csr_illegal !== 1'b0) begin n_fail++; $display("FAIL mtvec_illegal got %b exp 0", bus.o_csr_illegal); end
    tick();
    n_chk++; if (bus.o_mtvec !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_wr got %h exp %h", bus.o_mtvec, 32'h8000_0100); end
    drv(2'b01, 12'h305, 1'b1, 32'h1234_5678, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_rd got %h exp %h", bus.o_csr_rdata, 32'h8000_0100); end
    tick();
    n_chk++; if (bus.o_mtvec !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_nolsu got %h exp %h", bus.o_mtvec, 32'h8000_0100); end
    idle();
  endtask
  task automatic test_mstatus;
    drv(2'b10, 12'h300, 1'b1, 32'h8, 1'b1);
    n_chk++; if (bus.o_csr_rdata !== 32'h1800) begin n_fail++; $display("FAIL ms_old got %h exp 1800", bus.o_csr_rdata); end
    tick();
    n_chk++; if (bus.o_mstatus !== 32'h1808) begin n_fail++; $display("FAIL ms_rs got %h exp 1808", bus.o_mstatus); end
    drv(2'b11, 12'h300, 1'b1, 32'h1000, 1'b1);
    tick();
    n_chk++; if (bus.o_mstatus !== 32'h0808) begin n_fail++; $display("FAIL ms_rc got %h exp 0808", bus.o_mstatus); end
    drv(2'b10, 12'h300, 1'b0, 32'hFFFF_FFFF, 1'b1);
    n_chk++; if (bus.o_csr_rdata !== 32'h0808) begin n_fail++; $display("FAIL ms_rd got %h exp 0808", bus.o_csr_rdata); end
    tick();
    n_chk++; if (bus.o_mstatus !== 32'h0808) begin n_fail++; $display("FAIL ms_nowen got %h exp 0808", bus.o_mstatus); end
    idle();
    bus.i_mstatus_wen = 1'b1;
    bus.i_mstatus_wdata = 32'h0000_1888;
    tick();
    n_chk++; if (bus.o_mstatus !== 32'h1888) begin n_fail++; $display("FAIL ms_trap got %h exp 1888", bus.o_mstatus); end
    idle();
  endtask
  task automatic test_collision;
    drv(2'b01, 12'h341, 1'b1, 32'h1234, 1'b1);
    bus.i_mepc_wen = 1'b1;
    bus.i_mepc_wdata = 32'h8000_0010;
    tick();
    n_chk++; if (bus.o_mepc !== 32'h8000_0010) begin n_fail++; $display("FAIL coll_mepc got %h exp %h", bus.o_mepc, 32'h8000_0010); end
    bus.i_mepc_wen = 1'b0;
    bus.i_mcause_wen = 1'b1;
    bus.i_mcause_wdata = 32'd11;
    drv(2'b01, 12'h341, 1'b1, 32'h4, 1'b1);
    tick();
    n_chk++; if (bus.o_mepc !== 32'h4) begin n_fail++; $display("FAIL diff_mepc got %h exp 4", bus.o_mepc); end
    idle();
    drv(2'b10, 12'h342, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'd11) begin n_fail++; $display("FAIL diff_mcause got %h exp b", bus.o_csr_rdata); end
    idle();
    bus.i_mepc_wen = 1'b1;
    bus.i_mepc_wdata = 32'h8000_0013;
    tick();
    n_chk++; if (bus.o_mepc !== 32'h8000_0010) begin n_fail++; $display("FAIL mepc_mask_trap got %h exp %h", bus.o_mepc, 32'h8000_0010); end
    idle();
    drv(2'b01, 12'h341, 1'b1, 32'h0000_0107, 1'b1);
    tick();
    n_chk++; if (bus.o_mepc !== 32'h0000_0104) begin n_fail++; $display("FAIL mepc_mask_sw got %h exp 104", bus.o_mepc); end
    idle();
  endtask
  task automatic test_mcycle;
    drv(2'b01, 12'hB00, 1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    drv(2'b01, 12'hB80, 1'b1, 32'h0, 1'b1);
    tick();
    drv(2'b10, 12'hB00, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_lo_hold got %h exp ffffffff", bus.o_csr_rdata); end
    tick();
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_carry_lo got %h exp 0", bus.o_csr_rdata); end
    drv(2'b10, 12'hB80, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'h1) begin n_fail++; $display("FAIL cyc_carry_hi got %h exp 1", bus.o_csr_rdata); end
    drv(2'b01, 12'hB00, 1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    drv(2'b01, 12'hB80, 1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    drv(2'b10, 12'hB80, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_ones_hi got %h exp ffffffff", bus.o_csr_rdata); end
    tick();
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap_hi got %h exp 0", bus.o_csr_rdata); end
    drv(2'b10, 12'hB00, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap_lo got %h exp 0", bus.o_csr_rdata); end
    drv(2'b01, 12'hB00, 1'b1, 32'h0000_0100, 1'b0);
    tick();
    drv(2'b10, 12'hB00, 1'b0, 32'h0, 1'b0);
    n_chk++; if (bus.o_csr_rdata !== 32'h1) begin n_fail++; $display("FAIL cyc_nolsu got %h exp 1", bus.o_csr_rdata); end
    idle();
  endtask
  task automatic test_illegal;
    drv(2'b01, 12'hF11, 1'b1, 32'h0, 1'b1);
    n_chk++; if (bus.o_csr_rdata !== 32'h7973_7978) begin n_fail++; $display("FAIL mvendorid got %h exp 79737978", bus.o_csr_rdata); end
    n_chk++; if (bus.o_csr_illegal !== 1'b1) begin n_fail++; $display("FAIL ro_wr_illegal got %b exp 1", bus.o_csr_illegal); end
    tick();
    n_chk++; if (bus.o_csr_rdata !== 32'h7973_7978) begin n_fail++; $display("FAIL mvendorid_keep got %h exp 79737978", bus.o_csr_rdata); end
    drv(2'b10, 12'hF12, 1'b0, 32'h0, 1'b1);
    n_chk++; if (bus.o_csr_rdata !== 32'h0000_5F5F) begin n_fail++; $display("FAIL marchid got %h exp 5f5f", bus.o_csr_rdata); end
    n_chk++; if (bus.o_csr_illegal !== 1'b0) begin n_fail++; $display("FAIL ro_rd_illegal got %b exp 0", bus.o_csr_illegal); end
    drv(2'b10, 12'h7C0, 1'b0, 32'h0, 1'b1);
    n_chk++; if (bus.o_csr_rdata !== 32'h0) begin n_fail++; $display("FAIL unimpl_rd got %h exp 0", bus.o_csr_rdata); end
    n_chk++; if (bus.o_csr_illegal !== 1'b1) begin n_fail++; $display("FAIL unimpl_illegal got %b exp 1", bus.o_csr_illegal); end
    drv(2'b00, 12'h7C0, 1'b1, 32'h0, 1'b1);
    n_chk++; if (bus.o_csr_illegal !== 1'b0) begin n_fail++; $display("FAIL op0_illegal got %b exp 0", bus.o_csr_illegal); end
    idle();
  endtask
  initial begin
    idle();
    tick();
    test_reset();
    test_mtvec();
    test_mstatus();
    test_collision();
    test_mcycle();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
